// File: rtl/delapan_bit_bagi_seq_pkg.sv
// Shared definitions for the sequential 16/8 signed divider:
// FSM state encodings, datapath widths, reset/zero constants and
// small magnitude helpers. Optional feature macro used by the top:
// DIV_SATURATE_EN (saturate q on quotient overflow instead of wrapping).
package delapan_bit_bagi_seq_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER_N     = 16;
  localparam int CNT_W      = 4;

  // FSM encodings (2-bit)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Zero / reset constants
  localparam logic [DIVISOR_W-1:0]  ZERO_Q       = '0;
  localparam logic [DIVISOR_W-1:0]  ZERO_R       = '0;
  localparam logic [DIVISOR_W-1:0]  ZERO_DIVISOR = '0;
  localparam logic [DIVISOR_W:0]    ZERO_REM     = '0;
  localparam logic [DIVIDEND_W-1:0] ZERO_A       = '0;
  localparam logic [CNT_W-1:0]      ZERO_CNT     = '0;

  // Counter preload: ITER_N steps counted down to zero inclusive
  localparam logic [CNT_W-1:0]      CNT_START    = CNT_W'(ITER_N - 1);

  // Saturation limits for the signed 8-bit quotient
  localparam logic [DIVISOR_W-1:0]  SAT_POS      = 8'h7F;
  localparam logic [DIVISOR_W-1:0]  SAT_NEG      = 8'h80;

  // Magnitude of a signed 16-bit value; 32768 still fits as unsigned 16-bit
  function automatic logic [DIVIDEND_W-1:0] f_mag_a(input logic [DIVIDEND_W-1:0] v);
    return v[DIVIDEND_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of a signed 8-bit value; 128 still fits as unsigned 8-bit
  function automatic logic [DIVISOR_W-1:0] f_mag_b(input logic [DIVISOR_W-1:0] v);
    return v[DIVISOR_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/delapan_bit_bagi_seq_bagi_langkah.sv
// One restoring division step: shift the next dividend bit into the
// partial remainder, subtract |b| when it fits, emit the quotient bit.
// Purely combinational.
module bagi_langkah
  import delapan_bit_bagi_seq_pkg::*;
(
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_rem,
  output logic                 o_qbit
);

  logic [DIVISOR_W+1:0] w_shift;

  assign w_shift = {i_rem, i_bit};

  // Trial subtract; the difference is below |b| so 9 bits always hold it
  always_comb begin
    o_qbit = (w_shift >= {2'b00, i_divisor});
    o_rem  = o_qbit ? (w_shift[DIVISOR_W:0] - {1'b0, i_divisor})
                    : w_shift[DIVISOR_W:0];
  end

endmodule

// File: rtl/delapan_bit_bagi_seq.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor, truncating
// toward zero, 8-bit quotient and remainder, 18 cycles from the accepted
// enable edge to the done_bagi pulse.
// Build option: define DIV_SATURATE_EN to saturate q on quotient overflow;
// without it q carries the low 8 bits of the 16-bit quotient.
//
// Handshake: enable is a start request sampled only in IDLE; while busy=1
// it is ignored. done_bagi is a single-cycle strobe marking q/r/ovf valid;
// those outputs hold until the next completed operation. The done_bagi
// cycle is an IDLE cycle, so enable may be high in it to start again.
module delapan_bit_bagi_seq
  import delapan_bit_bagi_seq_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [DIVISOR_W-1:0]  q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done_bagi,
  output logic [1:0]            o_dbg_state
);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_a_raw;
  logic [DIVISOR_W-1:0]  r_b_raw;
  logic [DIVIDEND_W-1:0] r_dvd;      // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W:0]    r_rem;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic                  r_sign_a;
  logic                  r_sign_q;
  logic [DIVISOR_W-1:0]  r_q;
  logic [DIVISOR_W-1:0]  r_r;
  logic                  r_ovf;
  logic                  r_done;

  logic [DIVISOR_W:0]    w_rem_next;
  logic                  w_qbit;
  logic                  w_div_zero;
  logic                  w_q_ovf;
  logic [DIVISOR_W-1:0]  w_q_wrap;
  logic [DIVISOR_W-1:0]  w_q_fix;
  logic [DIVISOR_W-1:0]  w_r_fix;
  logic                  w_ovf_fix;

  bagi_langkah u_langkah (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  assign w_div_zero = (r_divisor == ZERO_DIVISOR);

  // Sign correction and range check of the finished magnitudes
  always_comb begin
    w_q_ovf  = r_sign_q ? (r_dvd > 16'd128) : (r_dvd > 16'd127);
    w_q_wrap = r_sign_q ? (~r_dvd[DIVISOR_W-1:0] + 1'b1) : r_dvd[DIVISOR_W-1:0];
    w_r_fix  = r_sign_a ? (~r_rem[DIVISOR_W-1:0] + 1'b1) : r_rem[DIVISOR_W-1:0];
`ifdef DIV_SATURATE_EN
    w_q_fix  = w_q_ovf ? (r_sign_q ? SAT_NEG : SAT_POS) : w_q_wrap;
`else
    w_q_fix  = w_q_wrap;
`endif
    w_ovf_fix = w_q_ovf;
    if (w_div_zero) begin
      w_q_fix   = ZERO_Q;
      w_r_fix   = ZERO_R;
      w_ovf_fix = 1'b1;
    end
  end

  // FSM, operand capture and iterative datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= ZERO_CNT;
      r_a_raw   <= ZERO_A;
      r_b_raw   <= ZERO_DIVISOR;
      r_dvd     <= ZERO_A;
      r_rem     <= ZERO_REM;
      r_divisor <= ZERO_DIVISOR;
      r_sign_a  <= 1'b0;
      r_sign_q  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_a_raw <= a;
            r_b_raw <= b;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_dvd     <= f_mag_a(r_a_raw);
          r_divisor <= f_mag_b(r_b_raw);
          r_sign_a  <= r_a_raw[DIVIDEND_W-1];
          r_sign_q  <= r_a_raw[DIVIDEND_W-1] ^ r_b_raw[DIVISOR_W-1];
          r_rem     <= ZERO_REM;
          r_cnt     <= CNT_START;
          r_state   <= ST_DIV;
        end
        ST_DIV: begin
          r_dvd <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
          r_rem <= w_rem_next;
          if (r_cnt == ZERO_CNT) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Result registers and completion strobe, updated only on the FIX edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q    <= ZERO_Q;
      r_r    <= ZERO_R;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      if (r_state == ST_FIX) begin
        r_q   <= w_q_fix;
        r_r   <= w_r_fix;
        r_ovf <= w_ovf_fix;
      end
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign ovf         = r_ovf;
  assign done_bagi   = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_delapan_bit_bagi_seq.sv
// Bench for the sequential signed divider: directed and random operands,
// expected {q,r,ovf} and completion cycle pushed at the enable edge and
// popped when done_bagi appears.
module tb_delapan_bit_bagi_seq;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] a;
  logic [7:0]  b;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;
  logic        busy;
  logic        done_bagi;
  logic [1:0]  o_dbg_state;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;

  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [16:0] mon_e;
  logic [16:0] mon_last = '0;
  int          mon_c;

  delapan_bit_bagi_seq dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .ovf         (ovf),
    .busy        (busy),
    .done_bagi   (done_bagi),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference: integer division truncates toward zero, % follows dividend
  function automatic logic [16:0] model(input logic [15:0] ma, input logic [7:0] mb);
    int av, bv, qi, ri;
    logic [7:0] qo, ro;
    logic ov;
    av = int'($signed(ma));
    bv = int'($signed(mb));
    if (bv == 0) return {8'h00, 8'h00, 1'b1};
    qi = av / bv;
    ri = av % bv;
    ov = (qi > 127) || (qi < -128);
    qo = qi[7:0];
    ro = ri[7:0];
`ifdef DIV_SATURATE_EN
    if (ov) qo = (qi > 0) ? 8'h7F : 8'h80;
`endif
    return {qo, ro, ov};
  endfunction

  // scoreboard: compare every completion against the queued expectation
  always @(negedge clock) begin
    if (reset && done_bagi) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        mon_last = mon_e;
        check("q", {24'd0, q}, {24'd0, mon_e[16:9]});
        check("r", {24'd0, r}, {24'd0, mon_e[8:1]});
        check("ovf", {31'd0, ovf}, {31'd0, mon_e[0]});
        check("latency", cyc, mon_c);
      end
    end
  end

  // driver: call at a falling edge; returns 1 time unit after the enable edge
  task automatic start_op(input logic [15:0] ta, input logic [7:0] tb_, input bit push);
    enable = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clock);
    #1;
    enable = 1'b0;
    a = 16'($urandom);
    b = 8'($urandom);
    if (push) begin
      exp_q.push_back(model(ta, tb_));
      exp_cyc_q.push_back(cyc + 18);
    end
  endtask

  // wait for done_bagi (bounded); optionally pulse enable mid-operation
  task automatic wait_done(input int pulse_at);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (done_bagi) seen = 1'b1;
      else check("busy_during", {31'd0, busy}, 32'd1);
      if (pulse_at >= 0 && n == pulse_at) begin
        enable = 1'b1;
        a = 16'($urandom);
        b = 8'($urandom);
      end else begin
        enable = 1'b0;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [7:0] tb_, input int pulse_at);
    start_op(ta, tb_, 1'b1);
    wait_done(pulse_at);
    @(negedge clock);
    check("done_one_cycle", {31'd0, done_bagi}, 32'd0);
    check("q_hold", {24'd0, q}, {24'd0, mon_last[16:9]});
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    a      = '0;
    b      = '0;

    @(negedge clock);
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done_bagi}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // directed operands, including a stray enable while busy
    run_op(16'd900,  8'd8,   5);
    run_op(16'hFC7C, 8'd8,  -1);
    run_op(16'd900,  8'hF8, -1);
    run_op(16'd2000, 8'd3,  -1);
    run_op(16'd1234, 8'h00, -1);
    run_op(16'h8000, 8'h80, -1);
    run_op(16'h8000, 8'h01, -1);
    run_op(16'h8000, 8'hFF, -1);
    run_op(16'h7FFF, 8'hFF, -1);
    run_op(16'hFF85, 8'h7F, -1);
    run_op(16'h0005, 8'hF9, -1);
    run_op(16'hFF80, 8'h80, 12);

    // back-to-back: new enable in the done_bagi cycle
    start_op(16'd900, 8'd8, 1'b1);
    wait_done(-1);
    start_op(16'hFC7C, 8'd7, 1'b1);
    wait_done(-1);
    start_op(16'd0, 8'h00, 1'b1);
    wait_done(-1);
    @(negedge clock);
    check("b2b_done_low", {31'd0, done_bagi}, 32'd0);

    // random operands, mixed back-to-back and spaced
    for (int i = 0; i < 12; i++) begin
      if (i[0]) begin
        start_op(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 1'b1);
        wait_done(-1);
      end else begin
        run_op(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), -1);
      end
    end
    @(negedge clock);

    // leave a nonzero result, then reset in the middle of an operation
    run_op(16'd900, 8'd8, -1);
    start_op(16'd2000, 8'd3, 1'b0);
    repeat (8) @(negedge clock);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mrst_q", {24'd0, q}, 32'd0);
    check("mrst_r", {24'd0, r}, 32'd0);
    check("mrst_ovf", {31'd0, ovf}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done_bagi}, 32'd0);
    check("mrst_state", {30'd0, o_dbg_state}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (25) @(negedge clock);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_q", {24'd0, q}, 32'd0);

    // recovery after reset
    run_op(16'hFC7C, 8'hF8, -1);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
